// File: rtl/noc_axi4_bridge_deser.sv
// Receive-side deserializer of the NoC<->AXI4 bridge: gathers header and payload
// flits of one request packet and presents them as a single handshaked beat.
//
// state       | meaning
// RECV_HEADER | collecting header flits; flit 0 carries the message length
// RECV_DATA   | collecting payload flits into AXI-width data slots
// SEND        | complete packet held on the outputs until out_rdy
module noc_axi4_bridge_deser #(
  parameter int SWAP_ENDIANESS = 0,
  parameter int NOC_W          = 64,
  parameter int AXI_W          = 512,
  parameter int HDR_FLITS      = 3,
  parameter int MSG_LEN_LSB    = 22,
  parameter int MSG_LEN_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NOC_W-1:0]           flit_in,
  input  logic                       flit_in_val,
  output logic                       flit_in_rdy,
  output logic [HDR_FLITS*NOC_W-1:0] header_out,
  output logic [AXI_W-1:0]           data_out,
  output logic                       out_val,
  input  logic                       out_rdy
);

  localparam int SLOTS = AXI_W / NOC_W;
  localparam int HIW   = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
  localparam int DIW   = $clog2(SLOTS) + 1;
  localparam int NB    = NOC_W / 8;

  typedef enum logic [1:0] {
    RECV_HEADER,
    RECV_DATA,
    SEND
  } state_t;

  state_t               state;
  logic [NOC_W-1:0]     hdr_mem [HDR_FLITS];
  logic [NOC_W-1:0]     dat_mem [SLOTS];
  logic [MSG_LEN_W-1:0] remaining;
  logic [HIW-1:0]       hdr_idx;
  logic [DIW-1:0]       dat_idx;
  logic [MSG_LEN_W-1:0] msg_len;
  logic [NOC_W-1:0]     flit_data;

  assign msg_len     = flit_in[MSG_LEN_LSB +: MSG_LEN_W];
  assign flit_in_rdy = (state != SEND);
  assign out_val     = (state == SEND);

  always_comb begin
    flit_data = flit_in;
    if (SWAP_ENDIANESS != 0) begin
      for (int b = 0; b < NB; b++) begin
        flit_data[b*8 +: 8] = flit_in[(NB-1-b)*8 +: 8];
      end
    end
  end

  // hdr_idx == 0 marks "next accepted flit is flit 0 of a new packet"
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RECV_HEADER;
      remaining <= '0;
      hdr_idx   <= '0;
      dat_idx   <= '0;
      for (int k = 0; k < HDR_FLITS; k++) hdr_mem[k] <= '0;
      for (int i = 0; i < SLOTS; i++) dat_mem[i] <= '0;
    end else begin
      case (state)
        RECV_HEADER: begin
          if (flit_in_val) begin
            if (hdr_idx == '0) begin
              for (int k = 1; k < HDR_FLITS; k++) hdr_mem[k] <= '0;
              for (int i = 0; i < SLOTS; i++) dat_mem[i] <= '0;
              hdr_mem[0] <= flit_in;
              remaining  <= msg_len;
              hdr_idx    <= HIW'(1);
              dat_idx    <= '0;
              if (msg_len == '0) begin
                state <= SEND;
              end else if (HDR_FLITS == 1) begin
                state <= RECV_DATA;
              end
            end else begin
              hdr_mem[hdr_idx] <= flit_in;
              remaining        <= remaining - 1'b1;
              if (remaining == MSG_LEN_W'(1)) begin
                state <= SEND;
              end else if (hdr_idx == HIW'(HDR_FLITS - 1)) begin
                state <= RECV_DATA;
              end else begin
                hdr_idx <= hdr_idx + 1'b1;
              end
            end
          end
        end

        RECV_DATA: begin
          if (flit_in_val) begin
            // payload beyond the AXI width is consumed but dropped
            if (dat_idx < DIW'(SLOTS)) begin
              dat_mem[dat_idx[DIW-2:0]] <= flit_data;
              dat_idx                   <= dat_idx + 1'b1;
            end
            if (remaining != '0) begin
              remaining <= remaining - 1'b1;
            end
            if (remaining <= MSG_LEN_W'(1)) begin
              state <= SEND;
            end
          end
        end

        SEND: begin
          if (out_rdy) begin
            state   <= RECV_HEADER;
            hdr_idx <= '0;
          end
        end

        default: state <= RECV_HEADER;
      endcase
    end
  end

  for (genvar k = 0; k < HDR_FLITS; k++) begin : g_hdr
    assign header_out[k*NOC_W +: NOC_W] = hdr_mem[k];
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_dat
    assign data_out[i*NOC_W +: NOC_W] = dat_mem[i];
  end

endmodule

// File: tb/tb_noc_axi4_bridge_deser.sv
// Bench for noc_axi4_bridge_deser: plain and byte-swapping instances share one
// flit stream and are checked against a packet-level model of the expected beat.
module tb_noc_axi4_bridge_deser;

  localparam int NOC_W = 64;
  localparam int AXI_W = 512;
  localparam int HDR   = 3;
  localparam int SLOTS = AXI_W / NOC_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NOC_W-1:0]     flit_in;
  logic                 flit_in_val;
  logic                 out_rdy;
  logic                 rdy0, rdy1, val0, val1;
  logic [HDR*NOC_W-1:0] hdr0, hdr1;
  logic [AXI_W-1:0]     dat0, dat1;

  always #5 clk = ~clk;

  noc_axi4_bridge_deser #(.SWAP_ENDIANESS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_in_val(flit_in_val),
    .flit_in_rdy(rdy0), .header_out(hdr0), .data_out(dat0),
    .out_val(val0), .out_rdy(out_rdy)
  );

  noc_axi4_bridge_deser #(.SWAP_ENDIANESS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_in_val(flit_in_val),
    .flit_in_rdy(rdy1), .header_out(hdr1), .data_out(dat1),
    .out_val(val1), .out_rdy(out_rdy)
  );

  int                   n_checks = 0;
  int                   n_fail   = 0;
  logic [NOC_W-1:0]     pkt[$];
  logic [HDR*NOC_W-1:0] exp_hdr;
  logic [AXI_W-1:0]     exp_d0, exp_d1;
  logic [NOC_W-1:0]     hold;

  task automatic chk(input string tag, input logic [AXI_W-1:0] got, input logic [AXI_W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NOC_W-1:0] bswap(input logic [NOC_W-1:0] x);
    logic [NOC_W-1:0] r;
    for (int b = 0; b < NOC_W / 8; b++) r[b*8 +: 8] = x[(NOC_W/8-1-b)*8 +: 8];
    return r;
  endfunction

  // Flit k < HDR is header slot k; later flits fill data slots in order until 8.
  task automatic build_model();
    exp_hdr = '0;
    exp_d0  = '0;
    exp_d1  = '0;
    for (int k = 0; k < pkt.size(); k++) begin
      if (k < HDR) exp_hdr[k*NOC_W +: NOC_W] = pkt[k];
      else if (k - HDR < SLOTS) begin
        exp_d0[(k-HDR)*NOC_W +: NOC_W] = pkt[k];
        exp_d1[(k-HDR)*NOC_W +: NOC_W] = bswap(pkt[k]);
      end
    end
  endtask

  function automatic logic [NOC_W-1:0] mk_hdr(input int len);
    logic [NOC_W-1:0] f;
    f = {$urandom, $urandom};
    f[29:22] = 8'(len);
    return f;
  endfunction

  task automatic make_pkt(input int len);
    pkt.delete();
    pkt.push_back(mk_hdr(len));
    for (int i = 0; i < len; i++) pkt.push_back({$urandom, $urandom});
  endtask

  task automatic send_pkt(input int gap_max, input int count);
    int n;
    n = (count < 0) ? pkt.size() : count;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        flit_in_val = 1'b0;
        flit_in     = {$urandom, $urandom};
        tick();
      end
      flit_in     = pkt[i];
      flit_in_val = 1'b1;
      chk("rdy_recv0", 512'(rdy0), 512'd1);
      chk("outval_recv1", 512'(val1), 512'd0);
      tick();
    end
    flit_in_val = 1'b0;
  endtask

  task automatic expect_out(input int stall, input bit hold_val);
    build_model();
    if (hold_val) begin
      flit_in     = hold;
      flit_in_val = 1'b1;
    end
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) out_rdy = 1'b1;
      chk("out_val0", 512'(val0), 512'd1);
      chk("out_val1", 512'(val1), 512'd1);
      chk("rdy_send", 512'(rdy0 | rdy1), 512'd0);
      chk("header0", 512'(hdr0), 512'(exp_hdr));
      chk("header1", 512'(hdr1), 512'(exp_hdr));
      chk("data0", dat0, exp_d0);
      chk("data1", dat1, exp_d1);
      tick();
    end
    out_rdy = 1'b0;
    chk("out_val_after", 512'(val0 | val1), 512'd0);
    chk("rdy_after", 512'({rdy0, rdy1}), 512'd3);
  endtask

  initial begin
    rst_n       = 1'b0;
    flit_in     = '0;
    flit_in_val = 1'b0;
    out_rdy     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out_val", 512'({val0, val1}), 512'd0);
    chk("rst_rdy", 512'({rdy0, rdy1}), 512'd3);
    chk("rst_header", 512'(hdr0 | hdr1), 512'd0);
    chk("rst_data", dat0 | dat1, 512'd0);

    // store, length 10, data slots 1..8
    make_pkt(10);
    for (int i = 0; i < SLOTS; i++) pkt[HDR+i] = 64'(i + 1);
    send_pkt(0, -1);
    chk("store_slot0", 512'(dat0[63:0]), 512'd1);
    chk("store_slot7", 512'(dat0[511:448]), 512'd8);
    expect_out(0, 1'b0);

    // load, length 2: header only
    make_pkt(2);
    send_pkt(0, -1);
    expect_out(0, 1'b0);

    // nc_store, length 3, swapped data check
    make_pkt(3);
    pkt[3] = 64'h0011223344556677;
    send_pkt(0, -1);
    chk("swap_const", dat1, 512'h7766554433221100);
    chk("noswap_const", dat0, 512'h0011223344556677);
    expect_out(0, 1'b0);

    // zero-length packet
    make_pkt(0);
    send_pkt(0, -1);
    expect_out(0, 1'b0);

    // backpressure: out_rdy low for 5 cycles with next header waiting
    make_pkt(4);
    send_pkt(0, -1);
    hold = mk_hdr(5);
    expect_out(5, 1'b1);
    make_pkt(5);
    pkt[0] = hold;
    send_pkt(0, -1);
    expect_out(0, 1'b0);

    // over-length payload with gaps, then a normal packet
    make_pkt(12);
    send_pkt(3, -1);
    expect_out(1, 1'b0);
    make_pkt(6);
    send_pkt(2, -1);
    expect_out(0, 1'b0);

    // reset after 4 flits of a 10-length packet, garbage while in reset
    make_pkt(10);
    send_pkt(0, 4);
    rst_n = 1'b0;
    for (int i = 4; i < 11; i++) begin
      flit_in     = pkt[i];
      flit_in_val = 1'b1;
      tick();
    end
    rst_n       = 1'b1;
    flit_in_val = 1'b0;
    chk("midrst_out_val", 512'({val0, val1}), 512'd0);
    chk("midrst_rdy", 512'({rdy0, rdy1}), 512'd3);
    chk("midrst_header", 512'(hdr0 | hdr1), 512'd0);
    chk("midrst_data", dat0 | dat1, 512'd0);
    make_pkt(10);
    send_pkt(1, -1);
    expect_out(0, 1'b0);

    // random packets
    for (int p = 0; p < 20; p++) begin
      make_pkt(int'($urandom_range(14, 0)));
      send_pkt(2, -1);
      expect_out(int'($urandom_range(2, 0)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
